jpeg_pipe_reg: RTL and testbench

- Parametrised, elastic pipeline register for the decoder datapath; generalises the plain 8-bit clocked register.
- Adds configurable data width and stage count, valid/ready handshake with full-throughput skid buffering, synchronous flush and an occupancy count.
- Sits between decoder stages, e.g. byte fetch -> Huffman decode and IDCT -> colour conversion.
- Breaks timing paths on the data, valid and ready paths without losing throughput.

---
 rtl/jpeg_pipe_pkg.sv | 22 ++
 rtl/jpeg_skid_stage.sv | 79 +++++++
 rtl/jpeg_pipe_reg.sv | 84 ++++++++
 tb/tb_jpeg_pipe_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pipe_pkg.sv
// Shared definitions for the elastic decoder pipeline register: default sizing,
// level-width helper and handshake assertion macros.
`ifndef JPEG_PIPE_SVA
`define JPEG_PIPE_SVA
`define JPP_ASSERT_HOLD(clk, rst_n, flush, vld, rdy, dat) \
    assert property (@(posedge clk) disable iff (!rst_n) \
        ((vld) && !(rdy) && !(flush)) |=> ((vld) && $stable(dat)))
`define JPP_ASSERT_NEVER(clk, rst_n, cond) \
    assert property (@(posedge clk) disable iff (!rst_n) !(cond))
`endif

package jpeg_pipe_pkg;

    localparam int DefDataW = 8;
    localparam int DefDepth = 2;

    // Level must represent 0..2*depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/jpeg_skid_stage.sv
// One elastic stage: main register M feeds downstream, skid register S catches
// the beat that arrives while M is stalled so the ready path stays registered.
module jpeg_skid_stage
    import jpeg_pipe_pkg::*;
#(
    parameter int DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] mData_q, mData_d;
    logic [DATA_W-1:0] sData_q, sData_d;
    logic              mValid_q, mValid_d;
    logic              sValid_q, sValid_d;
    logic              inAcc;
    logic              outAcc;

    assign in_ready  = !sValid_q;
    assign out_data  = mData_q;
    assign out_valid = mValid_q;
    assign inAcc     = in_valid && !sValid_q;
    assign outAcc    = mValid_q && out_ready;

    always_comb begin
        mData_d  = mData_q;
        sData_d  = sData_q;
        mValid_d = mValid_q;
        sValid_d = sValid_q;
        if (flush) begin
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (outAcc) begin
            if (sValid_q) begin
                mData_d  = sData_q;
                mValid_d = 1'b1;
                sValid_d = 1'b0;
            end else if (inAcc) begin
                mData_d  = in_data;
                mValid_d = 1'b1;
            end else begin
                mValid_d = 1'b0;
            end
        end else if (!mValid_q) begin
            if (inAcc) begin
                mData_d  = in_data;
                mValid_d = 1'b1;
            end
        end else if (inAcc) begin
            // M is stalled; park the beat in S, which closes in_ready next cycle.
            sData_d  = in_data;
            sValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mData_q  <= '0;
            sData_q  <= '0;
            mValid_q <= 1'b0;
            sValid_q <= 1'b0;
        end else begin
            mData_q  <= mData_d;
            sData_q  <= sData_d;
            mValid_q <= mValid_d;
            sValid_q <= sValid_d;
        end
    end

    `JPP_ASSERT_HOLD(clk, rst_n, flush, out_valid, out_ready, out_data);

endmodule

// File: rtl/jpeg_pipe_reg.sv
// Elastic pipeline register: DEPTH chained skid stages (latency DEPTH, capacity
// 2*DEPTH) plus a registered occupancy count, with synchronous flush.
module jpeg_pipe_reg
    import jpeg_pipe_pkg::*;
#(
    parameter int  DATA_W = DefDataW,
    parameter int  DEPTH  = DefDepth,
    localparam int LVL_W  = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level
);

    localparam logic [LVL_W-1:0] MaxLvl = LVL_W'(2 * DEPTH);

    logic [DATA_W-1:0] chainData  [DEPTH+1];
    logic              chainValid [DEPTH+1];
    logic              chainReady [DEPTH+1];
    logic [LVL_W-1:0]  level_q, level_d;
    logic              inAcc;
    logic              outAcc;

    assign chainData[0]      = in_data;
    assign chainValid[0]     = in_valid;
    assign chainReady[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        jpeg_skid_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .in_data  (chainData[k]),
            .in_valid (chainValid[k]),
            .in_ready (chainReady[k]),
            .out_data (chainData[k+1]),
            .out_valid(chainValid[k+1]),
            .out_ready(chainReady[k+1])
        );
    end

    assign in_ready  = chainReady[0];
    assign out_data  = chainData[DEPTH];
    assign out_valid = chainValid[DEPTH];
    assign level     = level_q;
    assign inAcc     = in_valid && in_ready;
    assign outAcc    = out_valid && out_ready;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({inAcc, outAcc})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    `JPP_ASSERT_HOLD(clk, rst_n, flush, out_valid, out_ready, out_data);
    `JPP_ASSERT_NEVER(clk, rst_n, level_q > MaxLvl);
    `JPP_ASSERT_NEVER(clk, rst_n, (level_q == MaxLvl) && inAcc);
    `JPP_ASSERT_NEVER(clk, rst_n, (level_q == '0) && outAcc);

endmodule

// File: tb/tb_jpeg_pipe_reg.sv
// Randomised scoreboard bench for jpeg_pipe_reg (DATA_W=8, DEPTH=2): a FIFO
// queue of accepted beats is the reference for order, level and latency.
module tb_jpeg_pipe_reg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int LVL_W  = $clog2(2 * DEPTH + 1);

    typedef struct {
        int data;
        int cycle;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic [LVL_W-1:0]  level;

    int    testsRun     = 0;
    int    testsFailed  = 0;
    int    cycle        = 0;
    int    rstEvents    = 0;
    int    seenRst      = 0;
    bit    checkLatency = 0;
    beat_t expQ[$];

    bit                havePrev  = 0;
    logic              prevValid = 0;
    logic              prevReady = 0;
    logic              prevFlush = 0;
    logic [DATA_W-1:0] prevData  = '0;

    jpeg_pipe_reg #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (inData),
        .in_valid (inValid),
        .in_ready (inReady),
        .out_data (outData),
        .out_valid(outValid),
        .out_ready(outReady),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;
    always @(negedge rst_n) rstEvents++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: inputs are stable at the falling edge, so every
    // handshake seen here is the one the next rising edge will commit.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n || seenRst != rstEvents) begin
            expQ.delete();
            havePrev = 0;
            seenRst  = rstEvents;
        end
        if (rst_n) begin
            checkOutput("level", int'(level), expQ.size());
            if (expQ.size() == 0) checkOutput("emptyOutValid", int'(outValid), 0);
            if (expQ.size() == 2 * DEPTH) checkOutput("fullInReady", int'(inReady), 0);
            if (havePrev && prevValid && !prevReady && !prevFlush) begin
                checkOutput("holdValid", int'(outValid), 1);
                checkOutput("holdData", int'(outData), int'(prevData));
            end
            if (outValid && outReady && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("outData", int'(outData), e.data);
                if (checkLatency) checkOutput("latency", cycle - e.cycle, DEPTH);
            end
            if (inValid && inReady && !flush) begin
                e.data  = int'(inData);
                e.cycle = cycle;
                expQ.push_back(e);
            end
            if (flush) expQ.delete();
            havePrev  = 1;
            prevValid = outValid;
            prevReady = outReady;
            prevFlush = flush;
            prevData  = outData;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "OutValid"}, int'(outValid), 0);
        checkOutput({tag, "OutData"}, int'(outData), 0);
        checkOutput({tag, "Level"}, int'(level), 0);
        checkOutput({tag, "InReady"}, int'(inReady), 1);
    endtask

    // Called at posedge+1; drives one cycle and returns whether the input beat was taken.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r,
                                 input logic f, input logic pulseReset, output logic acc);
        inValid  = v;
        inData   = d;
        outReady = r;
        flush    = f;
        if (pulseReset) begin
            #1 rst_n = 1'b0;
            #1 checkResetOutputs("midReset");
            #1 rst_n = 1'b1;
        end
        @(negedge clk);
        acc = v && inReady;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic             acc;
        int               count;
        int               cyc;
        logic [DATA_W-1:0] d;

        rst_n    = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        #3 checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: back-to-back beats, fixed latency, steady level of DEPTH.
        checkLatency = 1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0, acc);
            checkOutput("streamAccept", int'(acc), 1);
            if (i >= 1) checkOutput("streamLevel", int'(level), DEPTH);
        end
        idle(4);
        checkLatency = 0;
        checkOutput("streamDrained", int'(level), 0);

        // Backpressure: exactly 2*DEPTH beats fit, then drain in order.
        count = 0;
        d     = 8'hA0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, acc);
            if (acc) begin
                d++;
                count++;
            end
        end
        checkOutput("bpAccepted", count, 2 * DEPTH);
        checkOutput("bpInReady", int'(inReady), 0);
        checkOutput("bpLevel", int'(level), 2 * DEPTH);
        idle(8);
        checkOutput("bpInReadyBack", int'(inReady), 1);
        checkOutput("bpLevelEmpty", int'(level), 0);

        // Flush at level 3 with a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b0, 1'b0, acc);
        checkOutput("preFlushLevel", int'(level), 3);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("flushLevel", int'(level), 0);
        checkOutput("flushOutValid", int'(outValid), 0);
        checkOutput("flushInReady", int'(inReady), 1);
        idle(6);

        // Random traffic against the scoreboard.
        count = 0;
        cyc   = 0;
        while (count < 10000 && cyc < 60000) begin
            applyStimulus($urandom_range(0, 99) < 70, DATA_W'($urandom), $urandom_range(0, 99) < 60,
                          1'b0, 1'b0, acc);
            if (acc) count++;
            cyc++;
        end
        checkOutput("randomBeats", count, 10000);
        idle(10);
        checkOutput("randomDrained", int'(level), 0);

        // Asynchronous reset mid-stream, then restart from empty.
        checkLatency = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, DATA_W'(8'hC0 + i), 1'b1, 1'b0, i == 3, acc);
            checkOutput("rstStreamAccept", int'(acc), 1);
        end
        idle(4);
        checkLatency = 0;
        checkOutput("rstStreamDrained", int'(level), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
